// File: rtl/seq_multiplier32.sv
// Sequential unsigned 32x32->64 shift-add multiplier that drives an external
// ripple adder and waits SETTLE clocks for it before capturing each partial sum.
module seq_multiplier32 #(
   parameter int SETTLE = 3
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        start,
   input  logic [31:0] a,
   input  logic [31:0] b,
   output logic        busy,
   output logic        done,
   output logic [63:0] product,
   output logic [31:0] add_a,
   output logic [31:0] add_b,
   output logic        add_sub,
   input  logic [31:0] add_sum,
   input  logic        add_cout
);

   localparam logic [2:0] IDLE     = 3'd0;
   localparam logic [2:0] CHECK    = 3'd1;
   localparam logic [2:0] ADD_WAIT = 3'd2;
   localparam logic [2:0] DONE     = 3'd3;

   localparam int              WCNT_W    = (SETTLE > 1) ? $clog2(SETTLE) : 1;
   localparam logic [WCNT_W-1:0] SETTLE_M1 = WCNT_W'(SETTLE - 1);

   logic [2:0]        state_q, state_d;
   logic [31:0]       mcand_q, mcand_d;
   logic [31:0]       hi_q, hi_d;
   logic [31:0]       lo_q, lo_d;
   logic [4:0]        cnt_q, cnt_d;
   logic [WCNT_W-1:0] wcnt_q, wcnt_d;
   logic [63:0]       product_q, product_d;
   logic              busy_q, done_q;
   logic [31:0]       add_a_q, add_b_q;
   logic              bit_done;

   always_comb begin
      // NOTE: every comb output gets a default first so no path can infer a latch.
      state_d   = state_q;
      mcand_d   = mcand_q;
      hi_d      = hi_q;
      lo_d      = lo_q;
      cnt_d     = cnt_q;
      wcnt_d    = wcnt_q;
      product_d = product_q;
      bit_done  = 1'b0;

      case (state_q)
         IDLE, DONE: begin
            if (start) begin
               mcand_d = a;
               hi_d    = 32'd0;
               lo_d    = b;
               cnt_d   = 5'd0;
               state_d = CHECK;
            end else begin
               state_d = IDLE;
            end
         end
         CHECK: begin
            if (!lo_q[0]) begin
               hi_d     = {1'b0, hi_q[31:1]};
               lo_d     = {hi_q[0], lo_q[31:1]};
               bit_done = 1'b1;
            end else begin
               wcnt_d  = '0;
               state_d = ADD_WAIT;
            end
         end
         ADD_WAIT: begin
            wcnt_d = wcnt_q + 1'b1;
            // Capture the 33-bit adder result only once it has had SETTLE clocks.
            if (wcnt_q == SETTLE_M1) begin
               hi_d     = {add_cout, add_sum[31:1]};
               lo_d     = {add_sum[0], lo_q[31:1]};
               bit_done = 1'b1;
            end
         end
         default: state_d = IDLE;
      endcase

      if (bit_done) begin
         if (cnt_q == 5'd31) begin
            state_d   = DONE;
            product_d = {hi_d, lo_d};
         end else begin
            cnt_d   = cnt_q + 5'd1;
            state_d = CHECK;
         end
      end
   end

   always_ff @(posedge clk) begin
      // NOTE: sequential state uses non-blocking assignments so every register
      // samples pre-edge values regardless of statement order.
      if (reset) begin
         state_q   <= IDLE;
         mcand_q   <= '0;
         hi_q      <= '0;
         lo_q      <= '0;
         cnt_q     <= '0;
         wcnt_q    <= '0;
         product_q <= '0;
         busy_q    <= 1'b0;
         done_q    <= 1'b0;
         add_a_q   <= '0;
         add_b_q   <= '0;
      end else begin
         state_q   <= state_d;
         mcand_q   <= mcand_d;
         hi_q      <= hi_d;
         lo_q      <= lo_d;
         cnt_q     <= cnt_d;
         wcnt_q    <= wcnt_d;
         product_q <= product_d;
         busy_q    <= (state_d == CHECK) || (state_d == ADD_WAIT);
         done_q    <= (state_d == DONE);
         add_a_q   <= hi_d;
         add_b_q   <= mcand_d;
      end
   end

   assign busy    = busy_q;
   assign done    = done_q;
   assign product = product_q;
   assign add_a   = add_a_q;
   assign add_b   = add_b_q;
   assign add_sub = 1'b0;

endmodule
